// File: rtl/mac_layer_sequencer.sv
// mac_layer_sequencer
//
// Runs the MAC array datapath through one neural-network layer, one neuron at
// a time. For each neuron it clears the accumulator, reads the bias, streams
// the neuron's DMA beats into the array, triggers the read, waits for the
// datapath result and offers it on a valid/ready output stream.
//
// Optional feature:
//   MAC_SEQ_TIMEOUT_EN - abort a neuron that waits TIMEOUT cycles for mac_done.
//                        The abort returns to IDLE and raises a sticky
//                        err_timeout. When the macro is undefined, WAIT has no
//                        limit and err_timeout is tied to 0.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   start, num_neurons,
//   num_beats, mode           layer request (sampled in IDLE only)
//   busy, layer_done,
//   err_timeout               layer status
//   dma_valid / dma_ready     DMA beat handshake
//   bias_rd, bias_addr        bias cache read
//   mac_en, mac_clr,
//   mac_read_en, mac_op_mode  datapath controls
//   mac_done, mac_result      datapath result
//   out_valid / out_ready,
//   out_data, out_idx         per-neuron result stream
//
// state  | meaning
// IDLE   | no layer in progress; waits for start
// CLEAR  | clears the accumulator and reads the bias for neuron idx
// STREAM | accepts the neuron's DMA beats
// READ   | one-cycle read trigger to the datapath
// WAIT   | waits for mac_done
// OUTPUT | holds the result until the consumer accepts it

module mac_layer_sequencer #(
  parameter int NEURON_W = 8,
  parameter int BEAT_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NEURON_W-1:0] num_neurons,
  input  logic [BEAT_W-1:0]   num_beats,
  input  logic                mode,
  output logic                busy,
  output logic                layer_done,
  output logic                err_timeout,
  input  logic                dma_valid,
  output logic                dma_ready,
  output logic                bias_rd,
  output logic [ADDR_W-1:0]   bias_addr,
  output logic                mac_en,
  output logic                mac_clr,
  output logic                mac_read_en,
  output logic                mac_op_mode,
  input  logic                mac_done,
  input  logic [15:0]         mac_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [15:0]         out_data,
  output logic [NEURON_W-1:0] out_idx
);

  localparam logic [BEAT_W-1:0]   BEAT_ONE   = BEAT_W'(1);
  localparam logic [NEURON_W-1:0] NEURON_ONE = NEURON_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_READ,
    S_WAIT,
    S_OUTPUT
  } state_t;

  state_t              state_q, state_d;
  logic [NEURON_W-1:0] n_neurons_q, n_neurons_d;
  logic [NEURON_W-1:0] idx_q, idx_d;
  logic [NEURON_W-1:0] out_idx_q, out_idx_d;
  logic [BEAT_W-1:0]   n_beats_q, n_beats_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [15:0]         out_data_q, out_data_d;
  logic                mode_q, mode_d;
  logic                layer_done_q, layer_done_d;
  logic                tmo_hit;

`ifdef MAC_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  // Fires in the last allowed WAIT cycle when mac_done is still absent.
  assign tmo_hit = (state_q == S_WAIT) && !mac_done && (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    tmo_d = tmo_q;
    err_d = err_q;
    // READ always precedes WAIT, so clearing here gives a fresh count on entry.
    if (state_q == S_READ) begin
      tmo_d = '0;
    end else if ((state_q == S_WAIT) && !mac_done && !tmo_hit) begin
      tmo_d = tmo_q + TW'(1);
    end
    if ((state_q == S_IDLE) && start) begin
      err_d = 1'b0;
    end else if (tmo_hit) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  logic unused_cfg;
  assign unused_cfg  = ^TIMEOUT;
  assign tmo_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    n_neurons_d  = n_neurons_q;
    n_beats_d    = n_beats_q;
    mode_d       = mode_q;
    idx_d        = idx_q;
    beat_cnt_d   = beat_cnt_q;
    out_data_d   = out_data_q;
    out_idx_d    = out_idx_q;
    layer_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_neurons_d = num_neurons;
          // A zero beat count runs as a single beat.
          n_beats_d   = (num_beats == '0) ? BEAT_ONE : num_beats;
          mode_d      = mode;
          idx_d       = '0;
          if (num_neurons == '0) begin
            layer_done_d = 1'b1;
          end else begin
            state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        beat_cnt_d = '0;
        state_d    = S_STREAM;
      end
      S_STREAM: begin
        if (dma_valid) begin
          beat_cnt_d = beat_cnt_q + BEAT_ONE;
          if (beat_cnt_q == n_beats_q - BEAT_ONE) begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mac_done) begin
          out_data_d = mac_result;
          out_idx_d  = idx_q;
          state_d    = S_OUTPUT;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          if (idx_q == n_neurons_q - NEURON_ONE) begin
            layer_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            idx_d   = idx_q + NEURON_ONE;
            state_d = S_CLEAR;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      n_neurons_q  <= '0;
      n_beats_q    <= '0;
      mode_q       <= 1'b0;
      idx_q        <= '0;
      beat_cnt_q   <= '0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
      layer_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_neurons_q  <= n_neurons_d;
      n_beats_q    <= n_beats_d;
      mode_q       <= mode_d;
      idx_q        <= idx_d;
      beat_cnt_q   <= beat_cnt_d;
      out_data_q   <= out_data_d;
      out_idx_q    <= out_idx_d;
      layer_done_q <= layer_done_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign layer_done  = layer_done_q;
  assign dma_ready   = (state_q == S_STREAM);
  // Only combinational input-to-output path in the block.
  assign mac_en      = (state_q == S_STREAM) && dma_valid;
  assign mac_clr     = (state_q == S_CLEAR);
  assign bias_rd     = (state_q == S_CLEAR);
  assign bias_addr   = ADDR_W'(idx_q);
  assign mac_read_en = (state_q == S_READ);
  assign mac_op_mode = (state_q != S_IDLE) && mode_q;
  assign out_valid   = (state_q == S_OUTPUT);
  assign out_data    = out_data_q;
  assign out_idx     = out_idx_q;

endmodule
